unified_mem_arbiter: RTL

- Shares one single-ported unified memory between the pipeline's instruction-fetch port and its data (MEM-stage) port.
- Arbitrates between the two ports, sequences one outstanding memory transaction at a time, and returns read data or write acknowledge to the owning port.
- Generates per-port stall signals that the pipeline uses to freeze the PC and the IF/ID registers (fetch) or the EX/MEM and MEM/WB registers (data).

---
 rtl/unified_mem_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/unified_mem_arbiter.sv
// Purpose: shares one single-ported unified memory between the fetch port and the data port.
// Latency: 3 cycles minimum (req -> mem_req -> mem_rvalid -> valid pulse); one transaction in flight.
// Backpressure: mem_gnt low holds mem_req and its payload stable; each port sees *_stall until its valid pulse.
//
// Ports:
//   clk, rst                      clock and asynchronous active-low reset
//   i_req/i_addr -> i_rdata/i_valid/i_stall                 instruction-fetch port
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_valid/d_stall    data (MEM-stage) port
//   err                           pulses with the owner's valid when a transaction times out
//   mem_req/mem_we/mem_addr/mem_wdata, mem_gnt/mem_rvalid/mem_rdata   memory side
module unified_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t        state;
  logic          owner_d;     // 1: data port owns the outstanding transaction
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] to_cnt;

  logic i_elig;
  logic d_elig;
  logic grant_i;
  logic grant_d;

  // A port whose completion is being signalled this cycle is not eligible,
  // otherwise the still-asserted req would be granted a second time.
  assign i_elig  = i_req & ~i_valid;
  assign d_elig  = d_req & ~d_valid;
  assign grant_i = i_elig & (~d_elig | (starve_cnt == STARVE_MAX));
  assign grant_d = d_elig & ~grant_i;

  assign i_stall = i_req & ~i_valid;
  assign d_stall = d_req & ~d_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      owner_d    <= 1'b0;
      starve_cnt <= '0;
      to_cnt     <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_valid    <= 1'b0;
      d_valid    <= 1'b0;
      err        <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      err     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_i) begin
            owner_d    <= 1'b0;
            mem_addr   <= i_addr;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            mem_req    <= 1'b1;
            starve_cnt <= '0;
            state      <= S_REQ;
          end else if (grant_d) begin
            owner_d   <= 1'b1;
            mem_addr  <= d_addr;
            mem_we    <= d_we;
            mem_wdata <= d_wdata;
            mem_req   <= 1'b1;
            // Only data grants that bypass a waiting fetch count toward starvation.
            if (i_req && (starve_cnt != STARVE_MAX)) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
            state <= S_REQ;
          end
        end
        S_REQ: begin
          // A response arriving together with the grant belongs to nothing we issued.
          if (mem_gnt) begin
            mem_req <= 1'b0;
            to_cnt  <= '0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            if (owner_d) begin
              d_valid <= 1'b1;
              d_rdata <= mem_rdata;
            end else begin
              i_valid <= 1'b1;
              i_rdata <= mem_rdata;
            end
            state <= S_IDLE;
          end else if (to_cnt == TO_LAST) begin
            // Last permitted WAIT cycle without a response: complete with an error.
            if (owner_d) begin
              d_valid <= 1'b1;
              d_rdata <= '0;
            end else begin
              i_valid <= 1'b1;
              i_rdata <= '0;
            end
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
